serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: operands a, b, cin are valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: first operand, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: second operand, unsigned.
REQ-008 SHALL have port cin, input, 1 bit: carry-in for the LSB.
REQ-009 SHALL have port out_valid, output, 1 bit: sum and cout are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: bit WIDTH of a+b+cin.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, SHALL capture a, b and cin into internal shift and carry registers, clear the bit counter and the sum register, and go to SHIFT.
REQ-015 SHIFT: SHALL process one bit per cycle, LSB first, through a single one-bit full-adder stage: s = a0^b0^c; c_next = a0&b0 | a0&c | b0&c.
REQ-016 SHIFT: each cycle SHALL shift a and b right by one, shift s into the sum register MSB-first (ending with bit 0 at sum[0]), and register c_next into the carry flip-flop.
REQ-017 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles; bit counter wraps to 0 on that transition.
REQ-018 DONE: out_valid=1, sum and cout stable; SHALL go to IDLE on out_ready, otherwise hold indefinitely with all outputs unchanged.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored and operands not sampled.
REQ-020 Latency: handshake accepted at edge N results in out_valid=1 from edge N+WIDTH+1; throughput one result per WIDTH+2 cycles when out_ready is held high.
REQ-021 cout SHALL equal the carry flip-flop after the final SHIFT cycle; no overflow beyond WIDTH+1 bits is possible.
REQ-022 Input changes on a, b, cin after capture SHALL NOT affect the in-flight result.
REQ-023 out_ready asserted outside DONE SHALL have no effect.

Reset
REQ-024 rst=1 SHALL immediately, without a clock edge, force state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry flip-flop=0, bit counter=0, operand registers=0.
REQ-025 Reset asserted mid-SHIFT or in DONE SHALL discard the in-flight result; no out_valid pulse SHALL follow release.
REQ-026 First handshake SHALL be accepted on the first rising edge after rst deasserts.

Verification (WIDTH=8)
REQ-027 Reset then idle: rst pulse with no in_valid -> in_ready=1, out_valid=0, sum=0x00, cout=0 throughout.
REQ-028 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid exactly 9 cycles after accept.
REQ-029 Carry-in path: a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0.
REQ-030 Backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid, sum, cout held; new in_valid ignored (in_ready=0); result removed one cycle after out_ready=1.
REQ-031 Reset mid-operation: assert rst 3 cycles into SHIFT for a=0x12, b=0x34 -> outputs zero at once, no out_valid; next a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
REQ-032 Exhaustive/random: compare 1000 random (a, b, cin) triples plus all-zero and all-ones cases against a+b+cin with out_ready randomly toggled -> zero mismatches.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder stage, LSB first, computes a+b+cin.
// Latency: WIDTH+1 cycles from accept to out_valid; one result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             capture, last_bit, s_bit, c_nxt;

  assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_nxt    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so the first (LSB) result bit ends up at sum[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else if (capture) begin
      a_sh    <= a;
      b_sh    <= b;
      sum_sh  <= '0;
      carry   <= cin;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      sum_sh  <= {s_bit, sum_sh[WIDTH-1:1]};
      carry   <= c_nxt;
      bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=8; all checks sampled on the falling edge.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int lat;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at a falling edge with the DUT idle; returns at the first falling edge with out_valid.
  // lat counts cycles from the accept cycle (0) to the first out_valid cycle.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit rnd_rdy);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int hold);
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] es, input logic ec);
    launch(av, bv, cv, 1'b0);
    chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    drain(0);
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit          saw_valid;
    logic [W:0]  exp9;
    logic [W-1:0] ra, rb;
    logic        rc;

    // Asynchronous reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready || sum != '0 || cout) saw_valid = 1'b1;
    end
    chk("idle_stable", 32'(saw_valid), 32'd0);

    // Handshake on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    directed("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    directed("cin_path", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    directed("to_msb", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    directed("zeros", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    directed("ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: DONE held while new operands are offered
    launch(8'h3C, 8'h0F, 1'b1, 1'b0);
    chk("bp_lat", 32'(lat), 32'(W + 1));
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'h55; b = 8'hAA; cin = 1'b1;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h4C);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_released", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    // Reset three cycles into SHIFT
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_valid", 32'(saw_valid), 32'd0);
    directed("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // Random operands with random out_ready
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      launch(ra, rb, rc, 1'b1);
      chk("rnd_lat", 32'(lat), 32'(W + 1));
      chk("rnd_sum", 32'(sum), 32'(exp9[W-1:0]));
      chk("rnd_cout", 32'(cout), 32'(exp9[W]));
      drain(int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
